// File: rtl/mcpu_sequencer.sv
// mcpu_sequencer: multi-cycle MCPU control FSM; define MCPU_SEQ_PERFCNT_EN to build the retired/stalls counters.
// Controls decode combinationally from the current state; memory states stall on mem_ready or for MEM_LAT cycles.
module mcpu_sequencer #(
  parameter int MEM_LAT     = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             pc_we,
  output logic             ir_we,
  output logic             a_we,
  output logic             b_we,
  output logic             ben_we,
  output logic             reg_we,
  output logic             memin,
  output logic [1:0]       dst,
  output logic [1:0]       regin,
  output logic [1:0]       alusrca,
  output logic [1:0]       alusrcb,
  output logic [2:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] stalls
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JAL      = 4'd11,
    S_JR       = 4'd12,
    S_FAULT    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  // Wait counter must hold both the fixed latency and the timeout threshold.
  localparam int WMAX   = (MEM_LAT > MEM_TIMEOUT) ? MEM_LAT : MEM_TIMEOUT;
  localparam int WC_W   = $clog2(WMAX + 2);
  localparam int LAT_M1 = (MEM_LAT > 0) ? MEM_LAT - 1 : 0;
  localparam int TO_M1  = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  state_t          cur;
  state_t          nxt;
  state_t          dispatch;
  logic [WC_W-1:0] wait_cnt;
  logic            is_mem;
  logic            done;
  logic            timeout_hit;
  logic [5:0]      op;
  logic [5:0]      funct;
  logic            instr_unused;

  assign op           = instr[31:26];
  assign funct        = instr[5:0];
  assign instr_unused = ^instr[25:6];
  assign state        = cur;
  assign is_mem       = (cur == S_FETCH) || (cur == S_MEM_RD) || (cur == S_MEM_WR);

  always_comb begin
    done        = 1'b0;
    timeout_hit = 1'b0;
    if (MEM_LAT == 0) begin
      done = is_mem && !reset && mem_ready;
      if (MEM_TIMEOUT != 0)
        timeout_hit = is_mem && !done && (wait_cnt == WC_W'(TO_M1));
    end else begin
      done = is_mem && !reset && (wait_cnt == WC_W'(LAT_M1));
    end
  end

  always_comb begin
    dispatch = S_FAULT;
    case (op)
      OP_RTYPE: begin
        if (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT) dispatch = S_EXEC_R;
        else if (funct == FN_JR)                                    dispatch = S_JR;
      end
      OP_ADDI, OP_XORI: dispatch = S_EXEC_I;
      OP_LW, OP_SW:     dispatch = S_MEM_ADDR;
      OP_BEQ, OP_BNE:   dispatch = S_BRANCH;
      OP_J:             dispatch = S_JUMP;
      OP_JAL:           dispatch = S_JAL;
      default:          dispatch = S_FAULT;
    endcase
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:    nxt = done ? S_DECODE : S_FETCH;
      S_DECODE:   nxt = dispatch;
      S_EXEC_R:   nxt = S_ALU_WB;
      S_EXEC_I:   nxt = S_ALU_WB;
      S_MEM_ADDR: nxt = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   nxt = done ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   nxt = done ? S_FETCH : S_MEM_WR;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: nxt = S_FETCH;
      default:    nxt = S_FAULT;
    endcase
    if (timeout_hit) nxt = S_FAULT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur      <= S_FETCH;
      halted   <= 1'b0;
      wait_cnt <= '0;
    end else begin
      cur <= nxt;
      if (nxt == S_FAULT) halted <= 1'b1;
      if (!is_mem || done || nxt == S_FAULT) wait_cnt <= '0;
      else                                   wait_cnt <= wait_cnt + WC_W'(1);
    end
  end

  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    pc_we   = 1'b0;
    ir_we   = 1'b0;
    a_we    = 1'b0;
    b_we    = 1'b0;
    ben_we  = 1'b0;
    reg_we  = 1'b0;
    memin   = 1'b0;
    dst     = 2'd0;
    regin   = 2'd0;
    alusrca = 2'd0;
    alusrcb = 2'd0;
    aluop   = ALU_ADD;
    pcsrc   = 2'd0;
    case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'd3;
        if (done) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          pcsrc = 2'd2;
        end
      end
      S_DECODE: begin
        a_we   = 1'b1;
        b_we   = 1'b1;
        ben_we = 1'b1;
      end
      S_EXEC_R: begin
        alusrca = 2'd1;
        alusrcb = 2'd2;
        if (funct == FN_SUB)      aluop = ALU_SUB;
        else if (funct == FN_SLT) aluop = ALU_SLT;
      end
      S_EXEC_I: begin
        alusrca = 2'd1;
        alusrcb = 2'd1;
        if (op == OP_XORI) aluop = ALU_XOR;
      end
      S_ALU_WB: begin
        reg_we = 1'b1;
        regin  = 2'd1;
        dst    = (op == OP_RTYPE) ? 2'd0 : 2'd1;
      end
      S_MEM_ADDR: begin
        alusrca = 2'd1;
        alusrcb = 2'd1;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        memin   = 1'b1;
      end
      S_MEM_WB: begin
        reg_we = 1'b1;
        dst    = 2'd1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        memin   = 1'b1;
        mem_we  = done;
      end
      S_BRANCH: begin
        alusrca = 2'd1;
        alusrcb = 2'd2;
        aluop   = ALU_SUB;
        pc_we   = zero ^ (op == OP_BNE);
      end
      S_JUMP: begin
        pc_we = 1'b1;
        pcsrc = 2'd1;
      end
      S_JAL: begin
        pc_we  = 1'b1;
        pcsrc  = 2'd1;
        reg_we = 1'b1;
        dst    = 2'd2;
        regin  = 2'd2;
      end
      S_JR: begin
        pc_we = 1'b1;
        pcsrc = 2'd3;
      end
      default: ;
    endcase
    // Reset aborts any access in flight: no write may leak out of it.
    if (reset) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      a_we    = 1'b0;
      b_we    = 1'b0;
      ben_we  = 1'b0;
      reg_we  = 1'b0;
    end
  end

`ifdef MCPU_SEQ_PERFCNT_EN
  logic [CNT_W-1:0] ret_q;
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ret_q   <= '0;
      stall_q <= '0;
    end else begin
      if (nxt == S_FETCH && cur != S_FETCH) ret_q <= ret_q + CNT_W'(1);
      if (is_mem && !done)                  stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign retired = ret_q;
  assign stalls  = stall_q;
`else
  assign retired = '0;
  assign stalls  = '0;
`endif

endmodule

// File: tb/tb_mcpu_sequencer.sv
// Scoreboarded bench: three sequencer builds (fixed lat 1, fixed lat 3 with 4-bit counters, handshake) run in turn.
module tb_mcpu_sequencer;
  localparam int TO = 16;
`ifdef MCPU_SEQ_PERFCNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_EXEC_R = 4'd2, ST_EXEC_I = 4'd3;
  localparam logic [3:0] ST_MEM_ADDR = 4'd4, ST_MEM_RD = 4'd5, ST_MEM_WB = 4'd6, ST_MEM_WR = 4'd7;
  localparam logic [3:0] ST_ALU_WB = 4'd8, ST_BRANCH = 4'd9, ST_JUMP = 4'd10, ST_JAL = 4'd11;
  localparam logic [3:0] ST_JR = 4'd12, ST_FAULT = 4'd15;

  localparam logic [7:0] E_REQ = 8'h80, E_WE = 8'h40, E_PC = 8'h20, E_IR = 8'h10;
  localparam logic [7:0] E_A = 8'h08, E_B = 8'h04, E_BEN = 8'h02, E_REG = 8'h01;
  localparam int P_MEMIN = 13, P_DST = 11, P_REGIN = 9, P_ASA = 7, P_ASB = 5, P_OP = 2, P_PC = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [7:0]  en;
    logic [13:0] sel;
    logic        halted;
    logic [31:0] ret;
    logic [31:0] stl;
  } obs_t;

  typedef struct {
    logic [3:0]  st;
    logic [7:0]  en;
    logic [13:0] sel;
    logic [13:0] msk;
    logic        halted;
    logic        care;
    logic [31:0] ret;
    logic [31:0] stl;
  } exp_t;

  logic        clk = 1'b0;
  logic [2:0]  rst;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  obs_t        o [3];
  int          dsel;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 0;
    localparam int CW  = (g == 1) ? 4 : 32;
    logic mem_req, mem_we, pc_we, ir_we, a_we, b_we, ben_we, reg_we, memin, halted;
    logic [1:0] dst, regin, alusrca, alusrcb, pcsrc;
    logic [2:0] aluop;
    logic [3:0] state;
    logic [CW-1:0] r, s;

    mcpu_sequencer #(.MEM_LAT(LAT), .MEM_TIMEOUT(TO), .CNT_W(CW)) u_dut (
      .clk(clk), .reset(rst[g]), .instr(instr), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .pc_we(pc_we), .ir_we(ir_we), .a_we(a_we),
      .b_we(b_we), .ben_we(ben_we), .reg_we(reg_we), .memin(memin), .dst(dst), .regin(regin),
      .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .state(state),
      .halted(halted), .retired(r), .stalls(s)
    );

    assign o[g] = {state, mem_req, mem_we, pc_we, ir_we, a_we, b_we, ben_we, reg_we,
                   memin, dst, regin, alusrca, alusrcb, aluop, pcsrc, halted, 32'(r), 32'(s)};
  end

  exp_t        q [$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic [13:0] e_sel, e_msk;
  logic        e_care;
  logic [31:0] m_ret, m_stl;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 0;
  endfunction

  function automatic logic [31:0] cmask();
    return (dsel == 1) ? 32'h0000_000F : 32'hFFFF_FFFF;
  endfunction

  function automatic void fld(input int lo, input int w, input int v);
    for (int i = 0; i < w; i++) begin
      e_sel[lo+i] = v[i];
      e_msk[lo+i] = 1'b1;
    end
  endfunction

  task automatic direct(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s dut%0d got %0d expected %0d", nm, dsel, got, want);
  endtask

  // One clock of expected behaviour; counters shown are those before this cycle's edge.
  task automatic cyc(input logic [3:0] st, input logic [7:0] en, input bit stall, input bit retire, input bit rdy);
    exp_t e;
    mem_ready = rdy;
    e.st = st; e.en = en; e.sel = e_sel; e.msk = e_msk;
    e.halted = (st == ST_FAULT); e.care = e_care;
    e.ret = PERF ? m_ret : 32'd0;
    e.stl = PERF ? m_stl : 32'd0;
    q.push_back(e);
    e_sel = '0; e_msk = '0;
    @(posedge clk); #1;
    if (stall)  m_stl = (m_stl + 1) & cmask();
    if (retire) m_ret = (m_ret + 1) & cmask();
  endtask

  task automatic cyc_nm(input logic [3:0] st, input logic [7:0] en, input bit retire);
    cyc(st, en, 1'b0, retire, 1'($urandom));
  endtask

  task automatic mem_sel(input logic [3:0] st);
    if (st == ST_FETCH) begin
      fld(P_MEMIN, 1, 0); fld(P_ASA, 2, 0); fld(P_ASB, 2, 3); fld(P_OP, 3, 0);
    end else begin
      fld(P_MEMIN, 1, 1);
    end
  endtask

  // w = waiting cycles before ready (handshake only); fixed builds always wait lat-1.
  task automatic access(input logic [3:0] st, input int w_in, output bit flt);
    int  w;
    bit  hs;
    int  n;
    logic [7:0] en;
    hs  = (lat_of(dsel) == 0);
    w   = hs ? w_in : lat_of(dsel) - 1;
    flt = hs && (w >= TO);
    n   = flt ? TO : w;
    for (int i = 0; i < n; i++) begin
      mem_sel(st);
      cyc(st, E_REQ, 1'b1, 1'b0, hs ? 1'b0 : 1'($urandom));
    end
    if (!flt) begin
      mem_sel(st);
      en = E_REQ;
      if (st == ST_FETCH) begin en = en | E_PC | E_IR; fld(P_PC, 2, 2); end
      if (st == ST_MEM_WR) en = en | E_WE;
      cyc(st, en, 1'b0, st == ST_MEM_WR, hs ? 1'b1 : 1'($urandom));
    end
  endtask

  task automatic decode_cyc();
    fld(P_ASA, 2, 0); fld(P_ASB, 2, 0); fld(P_OP, 3, 0);
    cyc_nm(ST_DECODE, E_A | E_B | E_BEN, 1'b0);
  endtask

  task automatic addr_cyc();
    fld(P_ASA, 2, 1); fld(P_ASB, 2, 1); fld(P_OP, 3, 0);
    cyc_nm(ST_MEM_ADDR, 8'h00, 1'b0);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm,
                           input int zv, output bit flt);
    bit bz;
    instr = {op, 20'($urandom), fn};
    zero  = 1'($urandom);
    access(ST_FETCH, wf, flt);
    if (!flt) begin
      decode_cyc();
      if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A)) begin
        fld(P_ASA, 2, 1); fld(P_ASB, 2, 2);
        fld(P_OP, 3, (fn == 6'h22) ? 1 : (fn == 6'h2A) ? 3 : 0);
        cyc_nm(ST_EXEC_R, 8'h00, 1'b0);
        fld(P_REGIN, 2, 1); fld(P_DST, 2, 0);
        cyc_nm(ST_ALU_WB, E_REG, 1'b1);
      end else if (op == 6'h00 && fn == 6'h08) begin
        fld(P_PC, 2, 3);
        cyc_nm(ST_JR, E_PC, 1'b1);
      end else if (op == 6'h08 || op == 6'h0E) begin
        fld(P_ASA, 2, 1); fld(P_ASB, 2, 1); fld(P_OP, 3, (op == 6'h0E) ? 2 : 0);
        cyc_nm(ST_EXEC_I, 8'h00, 1'b0);
        fld(P_REGIN, 2, 1); fld(P_DST, 2, 1);
        cyc_nm(ST_ALU_WB, E_REG, 1'b1);
      end else if (op == 6'h23 || op == 6'h2B) begin
        addr_cyc();
        if (op == 6'h23) begin
          access(ST_MEM_RD, wm, flt);
          if (!flt) begin
            fld(P_DST, 2, 1); fld(P_REGIN, 2, 0);
            cyc_nm(ST_MEM_WB, E_REG, 1'b1);
          end
        end else begin
          access(ST_MEM_WR, wm, flt);
        end
      end else if (op == 6'h04 || op == 6'h05) begin
        bz = (zv < 0) ? 1'($urandom) : (zv != 0);
        zero = bz;
        fld(P_ASA, 2, 1); fld(P_ASB, 2, 2); fld(P_OP, 3, 1); fld(P_PC, 2, 0);
        cyc_nm(ST_BRANCH, (bz ^ (op == 6'h05)) ? E_PC : 8'h00, 1'b1);
      end else if (op == 6'h02) begin
        fld(P_PC, 2, 1);
        cyc_nm(ST_JUMP, E_PC, 1'b1);
      end else if (op == 6'h03) begin
        fld(P_PC, 2, 1); fld(P_DST, 2, 2); fld(P_REGIN, 2, 2);
        cyc_nm(ST_JAL, E_PC | E_REG, 1'b1);
      end else begin
        flt = 1'b1;
      end
    end
  endtask

  task automatic fault_cycles(input int n);
    for (int i = 0; i < n; i++) cyc_nm(ST_FAULT, 8'h00, 1'b0);
  endtask

  // First reset cycle still shows the pre-reset state, so only the forced-off enables are checked.
  task automatic do_reset(input bit rdy);
    rst[dsel] = 1'b1;
    e_care = 1'b0;
    cyc(ST_FETCH, 8'h00, 1'b0, 1'b0, rdy);
    e_care = 1'b1;
    m_ret = 0; m_stl = 0;
    cyc(ST_FETCH, 8'h00, 1'b0, 1'b0, 1'($urandom));
    rst[dsel] = 1'b0;
  endtask

  task automatic rand_instr(input bit allow_bad, output logic [5:0] op, output logic [5:0] fn);
    int k;
    k  = int'($urandom_range(0, allow_bad ? 12 : 11));
    fn = 6'($urandom);
    op = 6'h00;
    case (k)
      0: fn = 6'h20;
      1: fn = 6'h22;
      2: fn = 6'h2A;
      3: fn = 6'h08;
      4: op = 6'h08;
      5: op = 6'h0E;
      6: op = 6'h23;
      7: op = 6'h2B;
      8: op = 6'h04;
      9: op = 6'h05;
      10: op = 6'h02;
      11: op = 6'h03;
      default: if (fn[0]) op = 6'h3F; else fn = 6'h21;
    endcase
  endtask

  exp_t me;
  obs_t ma;
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        me = q.pop_front();
        ma = o[dsel];
        n_chk++;
        if (ma.en === me.en && (ma.sel & me.msk) === (me.sel & me.msk) &&
            (!me.care || (ma.st === me.st && ma.halted === me.halted))) n_pass++;
        else $display("FAIL ctl dut%0d t=%0t state got %0d want %0d en got %b want %b sel got %h want %h (mask %h) halted got %b want %b",
                      dsel, $time, ma.st, me.st, ma.en, me.en, ma.sel & me.msk, me.sel & me.msk, me.msk, ma.halted, me.halted);
        if (me.care) begin
          n_chk++;
          if (ma.ret === me.ret && ma.stl === me.stl) n_pass++;
          else $display("FAIL counters dut%0d t=%0t retired got %0d want %0d stalls got %0d want %0d",
                        dsel, $time, ma.ret, me.ret, ma.stl, me.stl);
        end
      end
    end
  end

  initial begin
    bit          flt;
    logic [5:0]  op, fn;
    rst = 3'b111; instr = '0; zero = 1'b0; mem_ready = 1'b0; dsel = 0;
    e_sel = '0; e_msk = '0; e_care = 1'b1; m_ret = 0; m_stl = 0;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      rst  = 3'b111;
      dsel = d;
      do_reset(1'b0);
      if (d == 0) begin
        run_instr(6'h00, 6'h20, 0, 0, -1, flt);
        direct("add_retired", o[0].ret, PERF ? 32'd1 : 32'd0);
        run_instr(6'h03, 6'h00, 0, 0, -1, flt);
        run_instr(6'h05, 6'h00, 0, 0, 0, flt);
        run_instr(6'h04, 6'h00, 0, 0, 0, flt);
        run_instr(6'h3F, 6'h00, 0, 0, -1, flt);
        fault_cycles(20);
        direct("fault_halted", 32'(o[0].halted), 32'd1);
        do_reset(1'b1);
        direct("reset_state", 32'(o[0].st), 32'd0);
        direct("reset_halted", 32'(o[0].halted), 32'd0);
      end
      if (d == 2) begin
        run_instr(6'h23, 6'h00, 2, 2, -1, flt);
        direct("lw_stalls", o[2].stl, PERF ? 32'd4 : 32'd0);
      end
      for (int i = 0; i < 40; i++) begin
        rand_instr(d != 1, op, fn);
        run_instr(op, fn, $urandom_range(0, 4), $urandom_range(0, 4), -1, flt);
        if (flt) begin
          fault_cycles(3);
          do_reset(1'($urandom));
        end
      end
      if (d == 2) begin
        run_instr(6'h00, 6'h20, TO, 0, -1, flt);
        fault_cycles(3);
        direct("timeout_halted", 32'(o[2].halted), 32'd1);
        do_reset(1'b0);
        run_instr(6'h23, 6'h00, 1, TO + 4, -1, flt);
        fault_cycles(3);
        do_reset(1'b0);
        instr = {6'h2B, 26'($urandom)};
        access(ST_FETCH, 1, flt);
        decode_cyc();
        addr_cyc();
        for (int i = 0; i < 2; i++) begin
          mem_sel(ST_MEM_WR);
          cyc(ST_MEM_WR, E_REQ, 1'b1, 1'b0, 1'b0);
        end
        do_reset(1'b1);
        run_instr(6'h0E, 6'h00, 1, 0, -1, flt);
        direct("xori_after_abort_retired", o[2].ret, PERF ? 32'd1 : 32'd0);
      end
    end
    repeat (2) @(negedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain %0d entries left, want 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
